// File: rtl/reaction_timer_pkg.sv
// rtl/reaction_timer_pkg.sv - shared types and constants for the reaction timer
package reaction_timer_pkg;

    localparam int RT_W = 8;
    localparam logic [RT_W-1:0] RT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rt_state_e;

endpackage

// File: rtl/spi_tx_master.sv
// rtl/spi_tx_master.sv - mode 0 SPI master sending one byte per start, MSB first
module spi_tx_master #(
    parameter int SPI_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       cs_n_o,
    output logic [7:0] rx_o,
    output logic       busy_o
);

    localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       falls_q, falls_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_q, rx_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             ending_q, ending_d;

    always_comb begin
        div_d    = div_q;
        falls_d  = falls_q;
        shift_d  = shift_q;
        rx_d     = rx_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        busy_d   = busy_q;
        ending_d = ending_q;
        if (!busy_q) begin
            if (start_i) begin
                busy_d  = 1'b1;
                cs_n_d  = 1'b0;
                shift_d = data_i;
                mosi_d  = data_i[7];
                div_d   = '0;
                falls_d = '0;
                sclk_d  = 1'b0;
            end
        end else if (ending_q) begin
            // One extra cycle after the last falling edge before releasing the bus
            busy_d   = 1'b0;
            cs_n_d   = 1'b1;
            mosi_d   = 1'b0;
            ending_d = 1'b0;
        end else if (div_q == DIV_W'(SPI_DIV - 1)) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
                rx_d = {rx_q[6:0], miso_i};
            end else begin
                shift_d = {shift_q[6:0], 1'b0};
                mosi_d  = shift_q[6];
                falls_d = falls_q + 4'd1;
                if (falls_q == 4'd7) ending_d = 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= '0;
            falls_q  <= '0;
            shift_q  <= '0;
            rx_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            ending_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            falls_q  <= falls_d;
            shift_q  <= shift_d;
            rx_q     <= rx_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            busy_q   <= busy_d;
            ending_q <= ending_d;
        end
    end

    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign cs_n_o = cs_n_q;
    assign rx_o   = rx_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction time measurement with SPI result streaming
module reaction_timer_core
    import reaction_timer_pkg::*;
#(
    parameter int TICK_DIV = 10000,
    parameter int SPI_DIV  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            button,
    input  logic            led_on,
    output logic [RT_W-1:0] time_out,
    output logic            result_valid,
    output logic            spi_clk,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic            spi_cs,
    output logic [7:0]      spi_rx,
    output logic            spi_busy
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]      btn_sync_q, led_sync_q;
    logic            btn_prev_q, led_prev_q;
    rt_state_e       state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic [RT_W-1:0] cnt_q, cnt_d;
    logic [RT_W-1:0] time_q, time_d;
    logic            rv_q, rv_d;
    logic            spi_start;
    logic            btn_s, led_s, btn_rise, led_rise, led_fall, tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync_q <= '0;
            led_sync_q <= '0;
            btn_prev_q <= 1'b0;
            led_prev_q <= 1'b0;
        end else begin
            btn_sync_q <= {btn_sync_q[0], button};
            led_sync_q <= {led_sync_q[0], led_on};
            btn_prev_q <= btn_sync_q[1];
            led_prev_q <= led_sync_q[1];
        end
    end

    assign btn_s    = btn_sync_q[1];
    assign led_s    = led_sync_q[1];
    assign btn_rise = btn_s & ~btn_prev_q;
    assign led_rise = led_s & ~led_prev_q;
    assign led_fall = ~led_s & led_prev_q;
    assign tick     = (presc_q == PS_W'(TICK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        time_d    = time_q;
        rv_d      = 1'b0;
        spi_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (led_rise) begin
                    if (btn_s) begin
                        state_d   = DONE;
                        time_d    = RT_MAX;
                        rv_d      = 1'b1;
                        spi_start = 1'b1;
                    end else begin
                        state_d = RUN;
                        presc_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && cnt_q != RT_MAX) cnt_d = cnt_q + 8'd1;
                // A press reports the count as it stood before this cycle's tick
                if (btn_rise) begin
                    state_d   = DONE;
                    time_d    = cnt_q;
                    rv_d      = 1'b1;
                    spi_start = 1'b1;
                end else if (cnt_q == RT_MAX) begin
                    state_d   = DONE;
                    time_d    = RT_MAX;
                    rv_d      = 1'b1;
                    spi_start = 1'b1;
                end else if (led_fall) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (!led_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            time_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
            rv_q    <= rv_d;
        end
    end

    spi_tx_master #(.SPI_DIV(SPI_DIV)) u_spi (
        .clk    (clk),
        .rst    (rst),
        .start_i(spi_start),
        .data_i (time_d),
        .miso_i (spi_miso),
        .sclk_o (spi_clk),
        .mosi_o (spi_mosi),
        .cs_n_o (spi_cs),
        .rx_o   (spi_rx),
        .busy_o (spi_busy)
    );

    assign time_out     = time_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - scoreboard bench for reaction_timer_core
module tb_reaction_timer_core;

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] rx;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button = 1'b0;
    logic       led_on = 1'b0;
    logic       spi_miso = 1'b0;
    logic [7:0] time_out, spi_rx;
    logic       result_valid, spi_clk, spi_mosi, spi_cs, spi_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_count = 0;
    int frame_count = 0;
    logic [7:0] miso_pat = 8'h00;
    logic       abort_frame = 1'b0;

    logic [7:0] exp_time[$];
    frame_t     exp_frame[$];

    reaction_timer_core #(.TICK_DIV(4), .SPI_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .button      (button),
        .led_on      (led_on),
        .time_out    (time_out),
        .result_valid(result_valid),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_cs      (spi_cs),
        .spi_rx      (spi_rx),
        .spi_busy    (spi_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result monitor: every result_valid pulse pops one expected time_out
    always @(negedge clk) begin
        if (result_valid) begin
            rv_count++;
            if (exp_time.size() > 0) chk("time_out", time_out, exp_time.pop_front());
            else chk("rv_unexpected", exp_time.size(), 1);
        end
    end

    // SPI slave model: drives miso, collects mosi, checks frame at cs release
    logic [7:0] mon_bits;
    int mon_rise, mon_low;
    logic mon_in_frame = 1'b0;
    logic mon_sclk_prev = 1'b0;
    frame_t f;
    always @(negedge clk) begin
        if (!spi_cs) begin
            if (!mon_in_frame) begin
                mon_in_frame = 1'b1;
                mon_low = 0;
                mon_rise = 0;
                mon_bits = 8'h00;
            end
            mon_low++;
            if (spi_clk && !mon_sclk_prev) begin
                mon_bits = {mon_bits[6:0], spi_mosi};
                mon_rise++;
            end
            spi_miso = (mon_rise < 8) ? miso_pat[7 - mon_rise] : 1'b0;
        end else if (mon_in_frame) begin
            mon_in_frame = 1'b0;
            if (!abort_frame) begin
                frame_count++;
                if (exp_frame.size() > 0) begin
                    f = exp_frame.pop_front();
                    chk("frame_mosi", mon_bits, f.mosi);
                    chk("frame_rx", spi_rx, f.rx);
                    chk("frame_cs_low_clk", mon_low, 33);
                    chk("frame_rises", mon_rise, 8);
                end else begin
                    chk("frame_unexpected", exp_frame.size(), 1);
                end
            end
        end
        mon_sclk_prev = spi_clk;
    end

    task automatic wait_rv(input string tag, input int budget, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #2;
        end while (!result_valid && lat < budget);
        if (!result_valid) chk({tag, "_rv_timeout"}, result_valid, 1);
    endtask

    task automatic wait_frame(input string tag, input int start, input int budget);
        int n = 0;
        while (frame_count == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #6;
        chk({tag, "_frames"}, frame_count - start, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int lat, rv0, fr0;

    initial begin
        cycles(5);
        chk("rst_cs_held", spi_cs, 1);
        chk("rst_busy_held", spi_busy, 0);
        rst = 1'b0;
        cycles(2);
        chk("rst_time_out", time_out, 8'h00);
        chk("rst_cs", spi_cs, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_busy", spi_busy, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_rx", spi_rx, 8'h00);
        chk("rst_rv", result_valid, 0);

        // Press 40 clk after the LED: 39 RUN cycles before the press -> 9 ticks
        rv0 = rv_count; fr0 = frame_count;
        miso_pat = 8'hA5;
        exp_time.push_back(8'h09);
        exp_frame.push_back('{mosi: 8'h09, rx: 8'hA5});
        led_on = 1'b1;
        cycles(40);
        button = 1'b1;
        wait_rv("press", 100, lat);
        chk("press_window", (time_out >= 8'h09 && time_out <= 8'h0B), 1);
        wait_frame("press", fr0, 100);
        chk("press_rv_once", rv_count - rv0, 1);
        button = 1'b0;
        cycles(5);
        button = 1'b1;
        cycles(8);
        chk("done_press_time", time_out, 8'h09);
        chk("done_press_rv", rv_count - rv0, 1);
        button = 1'b0;
        led_on = 1'b0;
        cycles(10);

        // False start
        rv0 = rv_count; fr0 = frame_count;
        miso_pat = 8'h3C;
        button = 1'b1;
        cycles(6);
        exp_time.push_back(8'hFF);
        exp_frame.push_back('{mosi: 8'hFF, rx: 8'h3C});
        led_on = 1'b1;
        wait_rv("false", 20, lat);
        chk("false_latency", lat, 3);
        wait_frame("false", fr0, 100);
        button = 1'b0;
        led_on = 1'b0;
        cycles(10);

        // Timeout: 3 sync + 1020 ticks to reach 255 + 1 decision cycle
        rv0 = rv_count; fr0 = frame_count;
        miso_pat = 8'h5A;
        exp_time.push_back(8'hFF);
        exp_frame.push_back('{mosi: 8'hFF, rx: 8'h5A});
        led_on = 1'b1;
        wait_rv("timeout", 1200, lat);
        chk("timeout_latency", lat, 1024);
        wait_frame("timeout", fr0, 100);
        chk("timeout_rv_once", rv_count - rv0, 1);
        led_on = 1'b0;
        cycles(10);

        // LED drops without a press
        rv0 = rv_count; fr0 = frame_count;
        led_on = 1'b1;
        cycles(20);
        led_on = 1'b0;
        cycles(60);
        chk("abandon_time", time_out, 8'hFF);
        chk("abandon_rv", rv_count - rv0, 0);
        chk("abandon_frames", frame_count - fr0, 0);

        // Reset mid-RUN
        led_on = 1'b1;
        cycles(20);
        rst = 1'b1;
        #1;
        chk("rstrun_time", time_out, 8'h00);
        chk("rstrun_busy", spi_busy, 0);
        led_on = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(5);

        // Reset mid-frame
        button = 1'b1;
        cycles(6);
        exp_time.push_back(8'hFF);
        led_on = 1'b1;
        wait_rv("abort", 20, lat);
        cycles(6);
        chk("abort_cs_low", spi_cs, 0);
        abort_frame = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_cs", spi_cs, 1);
        chk("abort_sclk", spi_clk, 0);
        chk("abort_mosi", spi_mosi, 0);
        chk("abort_busy", spi_busy, 0);
        chk("abort_time", time_out, 8'h00);
        button = 1'b0;
        led_on = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(5);
        abort_frame = 1'b0;

        chk("sb_time_empty", exp_time.size(), 0);
        chk("sb_frame_empty", exp_frame.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
